// File: rtl/cube_move_sequencer.sv
// Move scheduler for the 2x2 cube controller: pending FIFO, undo history,
// LFSR scrambles, one move per strobe with a fixed settle gap.
module cube_move_sequencer #(
   parameter int         QDEPTH  = 8,
   parameter int         HDEPTH  = 16,
   parameter int         GAP     = 4,
   parameter int         SCR_LEN = 20,
   parameter logic [7:0] SEED    = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       active,
   input  logic [3:0] cmd_in,
   input  logic       cmd_valid,
   input  logic       undo,
   input  logic       scramble_start,
   output logic [3:0] command,
   output logic       ischanged,
   output logic       busy,
   output logic       drop,
   output logic [4:0] hist_count
);

   localparam int QW = $clog2(QDEPTH);
   localparam int HW = $clog2(HDEPTH);
   localparam int WW = $clog2(GAP + 1);
   localparam logic [QW:0] QFULL = QDEPTH[QW:0];
   localparam logic [4:0]  HFULL = 5'(HDEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT
   } state_t;

   state_t        r_state;
   logic [3:0]    r_fifo [QDEPTH];
   logic [QW:0]   r_wp;
   logic [QW:0]   r_rp;
   logic [3:0]    r_hist [HDEPTH];
   logic [HW-1:0] r_hp;
   logic          r_uflag;
   logic [7:0]    r_scr;
   logic [7:0]    r_lfsr;
   logic [WW-1:0] r_wcnt;

   logic [QW:0]   w_qcnt;
   logic          w_empty;
   logic          w_full;
   logic          w_push;
   logic          w_go;
   logic          w_sel_undo;
   logic          w_sel_fifo;
   logic          w_sel_scr;
   logic          w_issue;
   logic [HW-1:0] w_hp_dec;
   logic [3:0]    w_cand;
   logic [3:0]    w_scr_code;
   logic [3:0]    w_code;
   logic          w_fb;

   assign w_qcnt   = r_wp - r_rp;
   assign w_empty  = (w_qcnt == '0);
   assign w_full   = (w_qcnt == QFULL);
   assign w_push   = cmd_valid && (cmd_in <= 4'd13) && !w_full;
   assign w_go     = (r_state == S_IDLE) && active;
   assign w_sel_undo = w_go && r_uflag;
   assign w_sel_fifo = w_go && !r_uflag && !w_empty;
   assign w_sel_scr  = w_go && !r_uflag && w_empty
                       && (r_scr != 8'd0);
   assign w_hp_dec = r_hp - HW'(1);
   assign w_fb     = r_lfsr[7] ^ r_lfsr[5]
                     ^ r_lfsr[4] ^ r_lfsr[3];

   // Never follow a move with its own inverse: swap to the other face.
   assign w_cand     = {1'b0, r_lfsr[2:0]};
   assign w_scr_code = (w_cand == (command ^ 4'h1))
                       ? (w_cand ^ 4'h2) : w_cand;

   assign busy = (r_state != S_IDLE) || !w_empty
                 || r_uflag || (r_scr != 8'd0);

   always_comb begin
      w_code  = 4'h0;
      w_issue = 1'b0;
      unique case (1'b1)
         w_sel_undo: begin
            w_code  = r_hist[w_hp_dec] ^ 4'h1;
            w_issue = (hist_count != 5'd0);
         end
         w_sel_fifo: begin
            w_code  = r_fifo[r_rp[QW-1:0]];
            w_issue = 1'b1;
         end
         w_sel_scr: begin
            w_code  = w_scr_code;
            w_issue = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push)
         r_fifo[r_wp[QW-1:0]] <= cmd_in;
      if (w_issue && !w_sel_undo)
         r_hist[r_hp] <= w_code;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wp <= '0;
         drop <= 1'b0;
      end else begin
         drop <= cmd_valid && !w_push;
         if (w_push)
            r_wp <= r_wp + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_rp       <= '0;
         r_hp       <= '0;
         hist_count <= 5'd0;
         r_uflag    <= 1'b0;
         r_scr      <= 8'd0;
         r_lfsr     <= SEED;
         r_wcnt     <= '0;
         command    <= 4'hF;
         ischanged  <= 1'b0;
      end else begin
         ischanged <= 1'b0;
         if (w_sel_undo)
            r_uflag <= 1'b0;
         else if (undo)
            r_uflag <= 1'b1;
         if (w_sel_scr) begin
            r_scr  <= r_scr - 8'd1;
            r_lfsr <= {r_lfsr[6:0], w_fb};
         end else if (scramble_start && r_scr == 8'd0) begin
            r_scr <= 8'(SCR_LEN);
         end
         if (w_sel_fifo)
            r_rp <= r_rp + 1'b1;
         // Circular history: a full push overwrites the oldest slot.
         if (w_issue && w_sel_undo) begin
            r_hp       <= w_hp_dec;
            hist_count <= hist_count - 5'd1;
         end else if (w_issue) begin
            r_hp <= r_hp + HW'(1);
            if (hist_count != HFULL)
               hist_count <= hist_count + 5'd1;
         end
         unique case (r_state)
            S_IDLE: begin
               if (w_issue) begin
                  command   <= w_code;
                  ischanged <= 1'b1;
                  r_state   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_wcnt  <= '0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (r_wcnt == WW'(GAP - 1))
                  r_state <= S_IDLE;
               else
                  r_wcnt <= r_wcnt + WW'(1);
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cube_move_sequencer.sv
// Bench for cube_move_sequencer: queue-based behavioural model compared
// every cycle, plus directed scenario checks with literal expectations.
module tb_cube_move_sequencer;

   localparam int GAP = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       active;
   logic [3:0] cmd_in;
   logic       cmd_valid;
   logic       undo;
   logic       scramble_start;
   logic [3:0] command;
   logic       ischanged;
   logic       busy;
   logic       drop;
   logic [4:0] hist_count;

   cube_move_sequencer dut (
      .clk            (clk),
      .rst            (rst),
      .active         (active),
      .cmd_in         (cmd_in),
      .cmd_valid      (cmd_valid),
      .undo           (undo),
      .scramble_start (scramble_start),
      .command        (command),
      .ischanged      (ischanged),
      .busy           (busy),
      .drop           (drop),
      .hist_count     (hist_count)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Model state: what the scheduler must hold per the move rules.
   int         tcyc    = 0;
   int         m_ready = 0;
   logic [3:0] m_fifo[$];
   logic [3:0] m_hist[$];
   bit         m_flag;
   int         m_scr;
   logic [7:0] m_lfsr;
   logic [3:0] e_cmd;
   bit         e_ich;
   bit         e_drop;

   int         lg_cyc[$];
   logic [3:0] lg_cmd[$];
   int         n_drop = 0;

   task automatic model_step();
      int         s;
      logic [3:0] code;
      bit         iss;
      bit         hpush;
      bit         pre_full;
      bit         pre_flag;
      bit         pre_scr0;
      s        = tcyc;
      iss      = 0;
      hpush    = 0;
      code     = 4'h0;
      pre_full = (m_fifo.size() == 8);
      pre_flag = m_flag;
      pre_scr0 = (m_scr == 0);
      tcyc++;
      e_ich  = 0;
      e_drop = 0;
      if (s >= m_ready && active) begin
         if (m_flag) begin
            m_flag = 0;
            if (m_hist.size() > 0) begin
               code = m_hist.pop_back() ^ 4'h1;
               iss  = 1;
            end
         end else if (m_fifo.size() > 0) begin
            code  = m_fifo.pop_front();
            iss   = 1;
            hpush = 1;
         end else if (m_scr > 0) begin
            code = {1'b0, m_lfsr[2:0]};
            if (code == (e_cmd ^ 4'h1))
               code = code ^ 4'h2;
            m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5]
                      ^ m_lfsr[4] ^ m_lfsr[3]};
            m_scr--;
            iss   = 1;
            hpush = 1;
         end
      end
      if (iss) begin
         e_cmd   = code;
         e_ich   = 1;
         m_ready = s + GAP + 2;
      end
      if (hpush) begin
         m_hist.push_back(code);
         if (m_hist.size() > 16)
            void'(m_hist.pop_front());
      end
      if (cmd_valid) begin
         if (cmd_in > 4'd13 || pre_full)
            e_drop = 1;
         else
            m_fifo.push_back(cmd_in);
      end
      if (undo && !pre_flag)
         m_flag = 1;
      if (scramble_start && pre_scr0)
         m_scr = 20;
   endtask

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_fifo.delete();
            m_hist.delete();
            m_flag  = 0;
            m_scr   = 0;
            m_lfsr  = 8'hA5;
            e_cmd   = 4'hF;
            e_ich   = 0;
            e_drop  = 0;
            m_ready = 0;
         end else begin
            model_step();
         end
      end
   end

   initial begin
      bit eb;
      forever begin
         @(negedge clk);
         eb = (tcyc < m_ready) || (m_fifo.size() != 0)
              || m_flag || (m_scr != 0);
         chk("command", command, e_cmd);
         chk("ischanged", ischanged, e_ich);
         chk("drop", drop, e_drop);
         chk("busy", busy, eb);
         chk("hist_count", hist_count, m_hist.size());
         if (ischanged === 1'b1) begin
            lg_cyc.push_back(tcyc);
            lg_cmd.push_back(command);
         end
         if (drop === 1'b1)
            n_drop++;
      end
   end

   task automatic cyc_in(input logic v, input logic [3:0] c,
                         input logic u, input logic s);
      @(negedge clk);
      cmd_valid      = v;
      cmd_in         = c;
      undo           = u;
      scramble_start = s;
   endtask

   task automatic wait_n(input int n);
      repeat (n) cyc_in(1'b0, 4'h0, 1'b0, 1'b0);
   endtask

   task automatic clr_log();
      lg_cyc.delete();
      lg_cmd.delete();
   endtask

   task automatic lchk(input string nm, input int i,
                       input logic [3:0] exp);
      if (i < lg_cmd.size())
         chk(nm, lg_cmd[i], exp);
      else
         chk(nm, 32'hFFFF, exp);
   endtask

   task automatic tchk(input string nm, input int i, input int exp);
      if (i < lg_cyc.size())
         chk(nm, lg_cyc[i], exp);
      else
         chk(nm, -1, exp);
   endtask

   initial begin
      int         k;
      int         bad;
      logic [3:0] prev;
      logic [3:0] q[9];
      q = '{4'd0, 4'd3, 4'd4, 4'd7, 4'd8,
            4'd11, 4'd12, 4'd1, 4'd5};
      rst            = 1'b1;
      active         = 1'b0;
      cmd_valid      = 1'b0;
      cmd_in         = 4'h0;
      undo           = 1'b0;
      scramble_start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset_cmd", command, 4'hF);
      chk("reset_hist", hist_count, 0);

      // Two pushes back to back
      active = 1'b1;
      cyc_in(1'b1, 4'd0, 1'b0, 1'b0);
      k = tcyc;
      cyc_in(1'b1, 4'd2, 1'b0, 1'b0);
      wait_n(12);
      chk("t1_strobes", lg_cmd.size(), 2);
      lchk("t1_cmd0", 0, 4'd0);
      tchk("t1_cyc0", 0, k + 2);
      lchk("t1_cmd1", 1, 4'd2);
      tchk("t1_cyc1", 1, k + 8);
      chk("t1_hist", hist_count, 2);

      // Undo twice, then once more with empty history
      clr_log();
      cyc_in(1'b0, 4'd0, 1'b1, 1'b0);
      k = tcyc;
      wait_n(9);
      cyc_in(1'b0, 4'd0, 1'b1, 1'b0);
      wait_n(9);
      chk("t2_strobes", lg_cmd.size(), 2);
      lchk("t2_cmd0", 0, 4'd3);
      tchk("t2_cyc0", 0, k + 2);
      lchk("t2_cmd1", 1, 4'd1);
      chk("t2_hist", hist_count, 0);
      clr_log();
      cyc_in(1'b0, 4'd0, 1'b1, 1'b0);
      wait_n(10);
      chk("t2_silent", lg_cmd.size(), 0);

      // Fill FIFO while inactive, overflow and illegal code drop
      clr_log();
      n_drop = 0;
      active = 1'b0;
      cyc_in(1'b1, 4'd14, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++)
         cyc_in(1'b1, q[i], 1'b0, 1'b0);
      wait_n(10);
      chk("t3_nostrobe", lg_cmd.size(), 0);
      chk("t3_drops", n_drop, 2);
      chk("t3_busy_hold", busy, 1);
      active = 1'b1;
      wait_n(8 * (GAP + 2) + 6);
      chk("t3_strobes", lg_cmd.size(), 8);
      for (int i = 0; i < 8; i++)
         lchk("t3_order", i, q[i]);
      if (lg_cyc.size() >= 2)
         chk("t3_spacing", lg_cyc[1] - lg_cyc[0], GAP + 2);
      chk("t3_busy_end", busy, 0);
      chk("t3_hist", hist_count, 8);

      // Scramble with a second request mid-run
      clr_log();
      cyc_in(1'b0, 4'd0, 1'b0, 1'b1);
      wait_n(29);
      cyc_in(1'b0, 4'd0, 1'b0, 1'b1);
      wait_n(20 * (GAP + 2) + 20);
      chk("t4_strobes", lg_cmd.size(), 20);
      lchk("t4_first", 0, 4'd5);
      lchk("t4_second", 1, 4'd2);
      lchk("t4_third", 2, 4'd5);
      bad  = 0;
      prev = 4'd1;
      foreach (lg_cmd[i]) begin
         if (lg_cmd[i] > 4'd7 || lg_cmd[i] == (prev ^ 4'h1))
            bad++;
         prev = lg_cmd[i];
      end
      chk("t4_rule", bad, 0);
      chk("t4_hist_sat", hist_count, 16);
      chk("t4_busy_end", busy, 0);

      // History overflow: 17 moves, 17 undos
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      clr_log();
      for (int i = 0; i < 17; i++) begin
         cyc_in(1'b1, 4'(i % 14), 1'b0, 1'b0);
         wait_n(5);
      end
      wait_n(10);
      chk("t5_hist_full", hist_count, 16);
      for (int j = 0; j < 17; j++) begin
         cyc_in(1'b0, 4'd0, 1'b1, 1'b0);
         wait_n(7);
      end
      wait_n(5);
      chk("t5_strobes", lg_cmd.size(), 33);
      for (int i = 0; i < 17; i++)
         lchk("t5_fwd", i, 4'(i % 14));
      for (int j = 0; j < 16; j++)
         lchk("t5_undo", 17 + j, 4'((16 - j) % 14) ^ 4'h1);
      chk("t5_hist_end", hist_count, 0);

      // Reset in the middle of WAIT
      clr_log();
      cyc_in(1'b1, 4'd6, 1'b0, 1'b0);
      wait_n(4);
      chk("t6_pre", lg_cmd.size(), 1);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_cmd", command, 4'hF);
      chk("t6_rst_ich", ischanged, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_drop", drop, 0);
      chk("t6_rst_hist", hist_count, 0);
      @(negedge clk);
      #2 rst = 1'b0;
      clr_log();
      wait_n(20);
      chk("t6_quiet", lg_cmd.size(), 0);
      chk("t6_busy", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/cube_move_sequencer.md
# cube_move_sequencer

Move scheduler sitting in front of the 2x2 cube state controller. Collects move codes from the input decoder into a pending queue, keeps a history stack for undo and generates pseudo-random scrambles. It issues one move at a time on the controller's `command`/`ischanged` pair, with a guaranteed settle gap between moves.

## Interface
- `QDEPTH`, 8: pending-move FIFO depth (power of two).
- `HDEPTH`, 16: undo history depth (power of two).
- `GAP`, 4: idle cycles after each issued move (>=1).
- `SCR_LEN`, 20: moves per scramble (1..255).
- `SEED`, 8'hA5: LFSR reset value (nonzero).

- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `active` in 1: cube controller is in play state; issuing only while high.
- `cmd_in` in 4: move code (r=0, r'=1, f=2, f'=3, u=4, u'=5, l=6, l'=7, x=8, x'=9, y=10, y'=11, z=12, z'=13).
- `cmd_valid` in 1: one-cycle push strobe for `cmd_in`.
- `undo` in 1: one-cycle undo request.
- `scramble_start` in 1: one-cycle scramble request.
- `command` out 4: last issued move code, held between strobes.
- `ischanged` out 1: one-cycle strobe; controller applies `command` in that cycle.
- `busy` out 1: high whenever the FSM is not in IDLE, or work is pending (queue nonempty, undo flag set, scramble count nonzero).
- `drop` out 1: one-cycle pulse when a push is rejected.
- `hist_count` out 5: valid history entries (saturates at HDEPTH).

## Operation
- Reset values: `command`=4'hF, `ischanged`=0, `busy`=0, `drop`=0, `hist_count`=0. Reset also empties the FIFO, clears the undo flag and scramble count, and loads the LFSR with SEED. Reset mid-sequence aborts with no further strobes.
- **Push:**
  - `cmd_valid` with `cmd_in`<=13 and FIFO not full writes the FIFO.
  - Code 14/15 or FIFO full sets `drop` for 1 cycle and discards the code.
  - Pushes are accepted regardless of `active`.
  - Push and pop in the same cycle are both performed; with the FIFO full, a pop in the same cycle does not make room for the push.
- **Undo:** `undo` sets a sticky flag; repeated `undo` while the flag is set is ignored.
- **Scramble:** `scramble_start` loads the count with SCR_LEN only if the count is 0; otherwise it is ignored.
- **FSM states:** IDLE, ISSUE (1 cycle), WAIT (GAP cycles).
  - In IDLE with `active`=1, the source is chosen in priority order: undo flag, then FIFO nonempty, then scramble count>0.
  - Undo with `hist_count`=0: the flag is cleared, nothing is issued, and the FSM stays in IDLE.
  - Undo with history present: issue top^1 (inverse), pop history, decrement `hist_count`.
  - FIFO source: pop, issue, push onto history.
  - Scramble source:
    - Candidate is {1'b0, lfsr[2:0]} (faces r/f/u/l).
    - If the candidate equals the previous issued code^1, issue candidate^2 instead.
    - Advance the LFSR (taps 8,6,5,4), decrement the count, push onto history.
  - On selection: register `command`, set `ischanged`=1, go to ISSUE.
  - ISSUE -> WAIT.
  - WAIT -> IDLE after GAP cycles.
  - `active` falling mid-WAIT finishes the WAIT, then holds in IDLE.
- **History overflow:** circular stack; a push when full overwrites the oldest entry and `hist_count` stays at HDEPTH.

## Timing
- `cmd_valid` in cycle k, FSM idle and FIFO empty, `active`=1: `ischanged` high in cycle k+2.
- Back-to-back strobes are exactly GAP+2 cycles apart.
- `command` changes only in the same cycle `ischanged` rises.
- `undo` in cycle k, with the FSM idle: inverse strobe in cycle k+2.
- `drop` pulses in cycle k+1 for a rejected push in cycle k.

## Test plan
- Reset, `active`=1, push r(0), then f(2) in the next cycle -> `ischanged` in cycles k+2 and k+8 (GAP=4) with `command`=0 then 2; `hist_count`=2.
- After the above, pulse `undo` twice spaced 10 cycles -> strobes with `command`=3 then 1; `hist_count`=0; a third `undo` -> no strobe.
- With `active`=0, push 9 moves -> 9th gives `drop` pulse and no strobes. Raise `active` -> 8 strobes in FIFO order; `busy` falls after the last WAIT.
- `scramble_start` -> exactly 20 strobes, all codes 0..7, no code followed by its inverse; a second `scramble_start` mid-run does not extend it.
- Issue 17 moves, then undo 17 times -> 16 inverse strobes in reverse order, 17th undo silent.
- Assert `rst` in the middle of WAIT -> outputs at reset values immediately; no strobe after release until new input.
